// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master and its helper blocks.
package apb_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

    // Read data returned when a transfer is abandoned because the slave never answered.
    localparam logic [31:0] APB_DEADBEEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signal bundle for apb_cmd_master; the master modport is the
// requester's view, the slave modport is the view of whatever drives and consumes it.
interface apb_cmd_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait cycles; expired flags the wait edge on which the count reaches TIMEOUT.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{pclk, prst, clear, count_en};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int               CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count;

            always_ff @(posedge pclk) begin
                if (prst) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (count_en) begin
                    count <= count + CNT_W'(1);
                end
            end

            // Firing one count early lets the abort happen on the TIMEOUT-th wait edge itself.
            assign expired = count_en && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: one valid/ready command becomes one SETUP/ACCESS
// transfer whose completion is handed back on the valid/ready response stream.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             prst,
    apb_cmd_master_if.master bus
);

    apb_state_e state, state_next;

    logic accept;
    logic cmd_ready;
    logic psel;
    logic penable;
    logic rsp_valid;
    logic cnt_clear;
    logic cnt_en;
    logic expired;

    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (bus.pready || expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter restarts in SETUP so every ACCESS phase gets the full wait budget.
    assign cnt_clear = (state == SETUP);
    assign cnt_en    = (state == ACCESS) && !bus.pready;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .pclk     (pclk),
        .prst     (prst),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .expired  (expired)
    );

    // Request fields only move on accept; response fields only move on the completing edge,
    // so both stay stable for as long as the bus or the consumer needs them.
    always_ff @(posedge pclk) begin
        if (prst) begin
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
                pwrite_q <= bus.cmd_write;
            end
            if (state == ACCESS) begin
                if (bus.pready) begin
                    rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                    rsp_err_q     <= bus.pslverr;
                    rsp_timeout_q <= 1'b0;
                end else if (expired) begin
                    rsp_rdata_q   <= DATA_W'(APB_DEADBEEF);
                    rsp_err_q     <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel        = psel;
    assign bus.penable     = penable;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
